fire2_expand3_mac: RTL and testbench

//   Consumer of the fire2 expand3x3 weight ROM. Accepts one squeeze-layer activation per

---
 rtl/fire2_expand3_mac.sv | 117 +++++++++++
 tb/tb_fire2_expand3_mac.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fire2_expand3_mac.sv
// fire2 expand3x3 MAC array: NUM signed lanes sweep TAPS weight taps per pixel,
// then emit one requantised, ReLU'd output pixel over a valid/ready port.
module fire2_expand3_mac #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 7,
  parameter int NUM   = 64,
  parameter int TAPS  = 128,
  parameter int ACC_W = 40,
  parameter int FRAC  = 8,
  parameter int RELU  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             act_valid,
  input  logic [WIDTH-1:0] act_data,
  output logic             act_ready,
  output logic [ADDR-1:0]  rom_address,
  input  logic [WIDTH-1:0] rom_in [NUM],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data [NUM],
  output logic             busy
);

  typedef enum logic {ACCUM, OUT} state_t;

  localparam logic signed [ACC_W-1:0] QMAX =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] QMIN =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t state, state_nx;
  logic [ADDR-1:0] tap;
  logic signed [ACC_W-1:0] acc [NUM];
  logic signed [ACC_W-1:0] sum [NUM];
  logic signed [2*WIDTH-1:0] prod [NUM];
  logic [WIDTH-1:0] res [NUM];
  logic accept;
  logic last;

  // shift truncates toward -inf, then saturate and optionally clamp at zero
  function automatic logic [WIDTH-1:0] requant(
    input logic signed [ACC_W-1:0] r
  );
    logic signed [ACC_W-1:0] sh;
    sh = r >>> FRAC;
    if (RELU != 0 && sh[ACC_W-1]) return '0;
    if (sh > QMAX) return QMAX[WIDTH-1:0];
    if (sh < QMIN) return QMIN[WIDTH-1:0];
    return sh[WIDTH-1:0];
  endfunction

  assign act_ready   = (state == ACCUM);
  assign accept      = act_valid && act_ready;
  assign last        = (tap == ADDR'(TAPS-1));
  assign rom_address = tap;
  assign busy        = (tap != '0) || out_valid;

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      prod[i] = $signed(act_data) * $signed(rom_in[i]);
      sum[i]  = acc[i] +
        {{(ACC_W-2*WIDTH){prod[i][2*WIDTH-1]}}, prod[i]};
      res[i]  = requant(sum[i]);
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ACCUM;
    end else begin
      unique case (state)
        ACCUM: if (accept && last) state_nx = OUT;
        OUT:   if (out_valid && out_ready) state_nx = ACCUM;
        default: state_nx = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        acc[i]      <= '0;
        out_data[i] <= '0;
      end
    end else if (flush) begin
      tap       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM; i++) acc[i] <= '0;
    end else begin
      if (accept) begin
        if (last) begin
          tap       <= '0;
          out_valid <= 1'b1;
          for (int i = 0; i < NUM; i++) begin
            acc[i]      <= '0;
            out_data[i] <= res[i];
          end
        end else begin
          tap <= tap + 1'b1;
          for (int i = 0; i < NUM; i++) acc[i] <= sum[i];
        end
      end
      if (state == OUT && out_valid && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fire2_expand3_mac.sv
// Directed bench for fire2_expand3_mac: table of pixel vectors plus
// hand-written stall, gap, flush and async-reset sequences.
module tb_fire2_expand3_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        act_valid;
  logic [15:0] act_data;
  logic        act_ready;
  logic [6:0]  rom_address;
  logic [15:0] rom_in [64];
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data [64];
  logic        busy;

  int total = 0;
  int bad = 0;
  int mode = 0;
  int tap_ref = 0;

  always #5 clk = ~clk;

  fire2_expand3_mac dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .act_valid(act_valid), .act_data(act_data),
    .act_ready(act_ready), .rom_address(rom_address),
    .rom_in(rom_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  // ROM model: 0 lane i=i, 1 all 0x7FFF, 2 all -256, 3 lane0=tap else i
  always_comb begin
    for (int i = 0; i < 64; i++) begin
      case (mode)
        1: rom_in[i] = 16'h7FFF;
        2: rom_in[i] = 16'hFF00;
        3: rom_in[i] = (i == 0) ? {9'd0, rom_address} : 16'(i);
        default: rom_in[i] = 16'(i);
      endcase
    end
  end

  typedef struct {
    int          m;
    logic [15:0] a;
    int          e0;
    int          e1;
    int          e63;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic feed(input int n, input logic [15:0] a, input bit gaps);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 2000) begin
      guard++;
      act_data = a;
      act_valid = (gaps && $urandom_range(1, 0) == 1) ? 1'b0 : 1'b1;
      chk("rom_address", int'(rom_address), tap_ref);
      chk("ov_low", int'(out_valid), 0);
      chk("busy_acc", int'(busy), int'(tap_ref != 0));
      if (act_valid && act_ready) begin
        k++;
        tap_ref = (tap_ref + 1) % 128;
      end
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
    chk("feed_done", k, n);
  endtask

  task automatic check_out(input string tag, input int e0,
                           input int e1, input int e63);
    chk({tag, "_ov"}, int'(out_valid), 1);
    chk({tag, "_ready"}, int'(act_ready), 0);
    chk({tag, "_addr"}, int'(rom_address), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_l0"}, int'($signed(out_data[0])), e0);
    chk({tag, "_l1"}, int'($signed(out_data[1])), e1);
    chk({tag, "_l63"}, int'($signed(out_data[63])), e63);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("take_ov", int'(out_valid), 0);
    chk("take_ready", int'(act_ready), 1);
  endtask

  initial begin
    vecs[0] = '{0, 16'd256,    0,     128,   8064};
    vecs[1] = '{1, 16'h7FFF,   32767, 32767, 32767};
    vecs[2] = '{2, 16'd256,    0,     0,     0};
    vecs[3] = '{3, 16'd256,    8128,  128,   8064};
    vecs[4] = '{0, 16'd2,      0,     1,     63};
    vecs[5] = '{0, 16'hFF00,   0,     0,     0};
    vecs[6] = '{1, 16'd1,      16383, 16383, 16383};

    rst_n = 1'b0;
    flush = 1'b0;
    act_valid = 1'b0;
    act_data = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_ready", int'(act_ready), 1);
    chk("rst_addr", int'(rom_address), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(out_data[5]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].m;
      feed(128, vecs[v].a, 1'b0);
      check_out($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1,
                vecs[v].e63);
      take();
    end

    // stall output for 10 cycles, then the next pixel
    mode = 0;
    feed(128, 16'd256, 1'b0);
    for (int c = 0; c < 10; c++) begin
      act_valid = 1'b1;
      @(posedge clk); #1;
      check_out("stall", 0, 128, 8064);
    end
    act_valid = 1'b0;
    take();
    feed(128, 16'd256, 1'b0);
    check_out("after_stall", 0, 128, 8064);
    take();

    // random act_valid gaps
    feed(128, 16'd256, 1'b1);
    check_out("gaps", 0, 128, 8064);
    take();

    // flush at tap 50; act_valid high during flush must not count
    feed(50, 16'd256, 1'b0);
    chk("pre_flush_addr", int'(rom_address), 50);
    flush = 1'b1;
    act_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    act_valid = 1'b0;
    tap_ref = 0;
    chk("flush_addr", int'(rom_address), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_keep", int'(out_data[63]), 8064);

    // async reset at tap 30 of the next pixel
    feed(30, 16'd256, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", int'(rom_address), 0);
    chk("arst_ov", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_data", int'(out_data[63]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tap_ref = 0;
    @(posedge clk); #1;
    feed(128, 16'd256, 1'b0);
    check_out("post_rst", 0, 128, 8064);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
